// File: rtl/dff_checker.sv
// Response checker for a master-slave D flip-flop: a one-bit golden model compared
// against the observed q, a q/q_n complement check, and saturating counters with a sticky verdict.
`timescale 1ns/1ps
module dff_checker #(
  parameter int CNT_W       = 16,
  parameter bit STOP_ON_ERR = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             clear,
  input  logic             reset_n_obs,
  input  logic             d_obs,
  input  logic             q_obs,
  input  logic             q_n_obs,
  output logic             mismatch,
  output logic             comp_err,
  output logic [CNT_W-1:0] cmp_count,
  output logic [CNT_W-1:0] err_count,
  output logic [CNT_W-1:0] first_err_idx,
  output logic             fail,
  output logic [1:0]       state
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARM   = 2'd1,
    CHECK = 2'd2,
    FAIL  = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic               exp_val_q, exp_val_d;
  logic               exp_vld_q, exp_vld_d;
  logic               mismatch_q, mismatch_d;
  logic               comp_err_q, comp_err_d;
  logic [CNT_W-1:0]   cmp_q, cmp_d;
  logic [CNT_W-1:0]   err_q, err_d;
  logic [CNT_W-1:0]   fidx_q, fidx_d;
  logic               fail_q, fail_d;

  logic known, exp_now, mism, cerr, any_err;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  always_comb begin
    state_d    = state_q;
    exp_val_d  = exp_val_q;
    exp_vld_d  = exp_vld_q;
    mismatch_d = 1'b0;
    comp_err_d = 1'b0;
    cmp_d      = cmp_q;
    err_d      = err_q;
    fidx_d     = fidx_q;
    fail_d     = fail_q;

    // The DUT clears asynchronously, so a low reset_n_obs always implies an expected 0.
    known   = !reset_n_obs || exp_vld_q;
    exp_now = reset_n_obs & exp_val_q;
    mism    = known && (q_obs != exp_now);
    cerr    = (q_obs == q_n_obs);
    any_err = mism || cerr;

    if (state_q != IDLE) begin
      exp_val_d = reset_n_obs & d_obs;
      exp_vld_d = 1'b1;
    end

    unique case (state_q)
      IDLE: begin
        exp_vld_d = 1'b0;
        if (en) state_d = ARM;
      end
      ARM: state_d = en ? CHECK : IDLE;
      CHECK: begin
        mismatch_d = mism;
        comp_err_d = cerr;
        if (known) cmp_d = sat_inc(cmp_q);
        if (any_err) begin
          err_d = sat_inc(err_q);
          if (!fail_q) begin
            fidx_d = cmp_q;
            fail_d = 1'b1;
          end
        end
        if (any_err && STOP_ON_ERR) state_d = FAIL;
        else if (!en)               state_d = IDLE;
      end
      FAIL: state_d = FAIL;
      default: state_d = IDLE;
    endcase

    // Clear discards whatever this edge's compare produced.
    if (clear) begin
      state_d    = IDLE;
      exp_val_d  = 1'b0;
      exp_vld_d  = 1'b0;
      mismatch_d = 1'b0;
      comp_err_d = 1'b0;
      cmp_d      = '0;
      err_d      = '0;
      fidx_d     = '0;
      fail_d     = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      exp_val_q  <= 1'b0;
      exp_vld_q  <= 1'b0;
      mismatch_q <= 1'b0;
      comp_err_q <= 1'b0;
      cmp_q      <= '0;
      err_q      <= '0;
      fidx_q     <= '0;
      fail_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      exp_val_q  <= exp_val_d;
      exp_vld_q  <= exp_vld_d;
      mismatch_q <= mismatch_d;
      comp_err_q <= comp_err_d;
      cmp_q      <= cmp_d;
      err_q      <= err_d;
      fidx_q     <= fidx_d;
      fail_q     <= fail_d;
    end
  end

  assign mismatch      = mismatch_q;
  assign comp_err      = comp_err_q;
  assign cmp_count     = cmp_q;
  assign err_count     = err_q;
  assign first_err_idx = fidx_q;
  assign fail          = fail_q;
  assign state         = state_q;

endmodule
